// File: rtl/fetch_unit_pkg.sv
// CPU-wide widths and constants shared by the front-end blocks.
package fetch_unit_pkg;
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;
    localparam int CPU_REG_W  = 16;
    localparam int CPU_NREGS  = 8;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;
endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is a read of the storage registers.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = CPU_ADDR_W + CPU_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    // Guards keep the FIFO self-consistent even if a caller misbehaves.
    assign do_push = push && (count != DEPTH[$clog2(DEPTH+1)-1:0]);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives ROM address, captures returned words into a
// prefetch FIFO with their PCs, and handles execute-stage redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC),
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc, inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    used;
    logic              issue, push, pop;

    assign rom_addr = pc;

    // Credit counts the in-flight word but not a same-cycle pop, so the
    // FIFO always has room for whatever the ROM returns next cycle.
    assign used  = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign issue = !redirect_valid && (used < (CNT_W + 1)'(DEPTH));

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({inflight_pc, rom_data}),
        .head  ({instr_pc, instr_data}),
        .count (count)
    );
endmodule
